alu_div_seq: RTL

//  Iterative restoring divider for RV32M DIV/DIVU/REM/REMU, beside the single-cycle add/sub ALU.

---
 rtl/alu_div_seq.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/alu_div_seq.sv
// ---------------------------------------------------------------------------
// alu_div_seq
//   Iterative restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
//   A request is accepted in IDLE, runs DATA_W trial-subtract iterations in
//   CALC (one per clock), then presents the result in DONE with a single
//   o_valid pulse. The control unit stalls the PC while o_busy is high.
//
//   Optional feature macro: ALU_DIV_EARLY_EXIT_EN
//     When defined, divide-by-zero and signed overflow bypass CALC and go
//     straight to DONE at the accept edge. Results are identical either way.
//
// Ports
//   i_clk         in   1       clock, rising edge
//   i_rst_n       in   1       asynchronous active-low reset
//   i_start       in   1       start request, accepted only in IDLE
//   i_op          in   2       00 DIV, 01 DIVU, 10 REM, 11 REMU
//   i_div_a       in   DATA_W  dividend, sampled on accept
//   i_div_b       in   DATA_W  divisor, sampled on accept
//   o_busy        out  1       high in CALC and DONE
//   o_valid       out  1       one-cycle pulse, result ready
//   o_div_result  out  DATA_W  quotient or remainder; held until next DONE
// ---------------------------------------------------------------------------
module alu_div_seq #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [1:0]        i_op,
  input  logic [DATA_W-1:0] i_div_a,
  input  logic [DATA_W-1:0] i_div_b,
  output logic              o_busy,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_div_result
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] MIN_NEG  = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_q;       // dividend magnitude shifting out, quotient shifting in
  logic [DATA_W-1:0] r_rem;     // partial remainder
  logic [DATA_W-1:0] r_b_mag;   // divisor magnitude
  logic [DATA_W-1:0] r_a;       // original dividend, needed for the divide-by-zero remainder
  logic              r_is_rem;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_div0;
  logic              r_ovf;

  // Accept-side decode of the incoming operands
  logic              w_signed;
  logic [DATA_W-1:0] w_a_mag;
  logic [DATA_W-1:0] w_b_mag;
  logic              w_in_div0;
  logic              w_in_ovf;

  assign w_signed  = ~i_op[0];
  // -2^(W-1) negates to itself, which is exactly the unsigned magnitude wanted
  assign w_a_mag   = (w_signed && i_div_a[DATA_W-1]) ? -i_div_a : i_div_a;
  assign w_b_mag   = (w_signed && i_div_b[DATA_W-1]) ? -i_div_b : i_div_b;
  assign w_in_div0 = (i_div_b == '0);
  assign w_in_ovf  = w_signed && (i_div_a == MIN_NEG) && (i_div_b == '1);

  // One restoring iteration. The shifted remainder is W+1 bits wide; its
  // low W bits go through the A + ~B + 1 adder. When the top bit is set the
  // shifted value already exceeds any W-bit divisor, so there is no borrow
  // and the W-bit adder output is the exact difference.
  logic [DATA_W:0]   w_rem_shift;
  logic [DATA_W-1:0] w_diff;
  logic              w_carry;
  logic              w_no_borrow;
  logic [DATA_W-1:0] w_rem_next;
  logic [DATA_W-1:0] w_q_next;

  assign w_rem_shift          = {r_rem, r_q[DATA_W-1]};
  assign {w_carry, w_diff}    = {1'b0, w_rem_shift[DATA_W-1:0]} + {1'b0, ~r_b_mag}
                                + (DATA_W+1)'(1);
  assign w_no_borrow          = w_rem_shift[DATA_W] | w_carry;
  assign w_rem_next           = w_no_borrow ? w_diff : w_rem_shift[DATA_W-1:0];
  assign w_q_next             = {r_q[DATA_W-2:0], w_no_borrow};

  // Final result from the last iteration, with sign fix-up and forced cases
  logic [DATA_W-1:0] w_quot_fin;
  logic [DATA_W-1:0] w_rem_fin;
  logic [DATA_W-1:0] w_final;

  assign w_quot_fin = r_neg_q ? -w_q_next : w_q_next;
  assign w_rem_fin  = r_neg_r ? -w_rem_next : w_rem_next;

  always_comb begin
    w_final = r_is_rem ? w_rem_fin : w_quot_fin;
    if (r_div0) begin
      w_final = r_is_rem ? r_a : '1;
    end else if (r_ovf) begin
      w_final = r_is_rem ? '0 : MIN_NEG;
    end
  end

`ifdef ALU_DIV_EARLY_EXIT_EN
  logic [DATA_W-1:0] w_special_result;
  assign w_special_result = w_in_div0 ? (i_op[1] ? i_div_a : '1)
                                      : (i_op[1] ? '0 : MIN_NEG);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_q          <= '0;
      r_rem        <= '0;
      r_b_mag      <= '0;
      r_a          <= '0;
      r_is_rem     <= 1'b0;
      r_neg_q      <= 1'b0;
      r_neg_r      <= 1'b0;
      r_div0       <= 1'b0;
      r_ovf        <= 1'b0;
      o_busy       <= 1'b0;
      o_valid      <= 1'b0;
      o_div_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          o_valid <= 1'b0;
          if (i_start) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_q      <= w_a_mag;
            r_b_mag  <= w_b_mag;
            r_a      <= i_div_a;
            r_is_rem <= i_op[1];
            r_neg_q  <= w_signed && (i_div_a[DATA_W-1] ^ i_div_b[DATA_W-1]);
            r_neg_r  <= w_signed && i_div_a[DATA_W-1];
            r_div0   <= w_in_div0;
            r_ovf    <= w_in_ovf;
            o_busy   <= 1'b1;
`ifdef ALU_DIV_EARLY_EXIT_EN
            if (w_in_div0 || w_in_ovf) begin
              r_state      <= S_DONE;
              o_valid      <= 1'b1;
              o_div_result <= w_special_result;
            end else begin
              r_state <= S_CALC;
            end
`else
            r_state <= S_CALC;
`endif
          end
        end

        S_CALC: begin
          r_q   <= w_q_next;
          r_rem <= w_rem_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) begin
            r_state      <= S_DONE;
            o_valid      <= 1'b1;
            o_div_result <= w_final;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
